icache_responder: RTL and testbench
===================================

# icache_responder

Read-only, direct-mapped instruction cache that answers the fetch stage's ICACHE request port (read enable, word address, read data, stall) and refills whole blocks from a 128-bit instruction memory port. Hits return data combinationally in the request cycle. Misses hold `proc_stall` high while a single-outstanding block refill runs through a small FSM. Fetch-side writes are accepted and ignored. Two free-running counters expose hit and miss statistics.

## Interface
- `NUM_BLOCKS`, 8: number of 4-word blocks; power of two, at least 2. `IDX_W = log2(NUM_BLOCKS)`; `TAG_W = 28 - IDX_W`.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `proc_read` input 1: fetch read request.
- `proc_write` input 1: fetch write request; ignored.
- `proc_addr` input 30: word address. [1:0] = word in block, [IDX_W+1:2] = index, [29:IDX_W+2] = tag.
- `proc_wdata` input 32: ignored.
- `proc_stall` output 1: request not yet served.
- `proc_rdata` output 32: instruction word.
- `mem_read` output 1: block read request.
- `mem_write` output 1: tied 0.
- `mem_addr` output 28: block address.
- `mem_wdata` output 128: tied 0.
- `mem_rdata` input 128: refill data. Word k = bits [32k+31:32k].
- `mem_ready` input 1: `mem_rdata` valid this cycle.
- `hit_count` output 32: served read cycles.
- `miss_count` output 32: refills started.

## Operation
- Storage per block: valid bit, TAG_W tag, 128-bit data. Reset clears all valid bits only; tag and data arrays are not reset.
- `hit = valid[idx] && tag[idx] == proc_addr tag`. `proc_rdata` = word `proc_addr[1:0]` of `data[idx]`, always driven from the array. It is meaningful only when `proc_read && !proc_stall`.
- FSM state IDLE:
  - `proc_stall = proc_read && !hit`.
  - On `proc_read && !hit`: latch `proc_addr[29:2]` into `miss_addr`, increment `miss_count`, go to ALLOCATE.
  - On `proc_read && hit`: increment `hit_count`.
- FSM state ALLOCATE:
  - `proc_stall = 1`, `mem_read = 1`, `mem_addr = miss_addr`.
  - When `mem_ready = 1` at a clock edge: write `mem_rdata` into `data[miss_addr idx]`, write the tag, set valid, go to IDLE.
  - Otherwise remain in ALLOCATE.
- `mem_read = 0` and `mem_addr = 0` in IDLE.
- The refill always uses the latched `miss_addr`. `proc_addr` or `proc_read` changing during ALLOCATE does not alter or abort the refill. Data returned in that case may not be for the current request; the next IDLE cycle re-checks the current address.
- A refill into an occupied index evicts the old block silently; there are no dirty blocks.
- `proc_write` never causes a stall, a memory access or an array update, including when asserted together with `proc_read`.
- Both counters wrap modulo 2^32. A single fetch that is held asserted for several hit cycles counts once per cycle.

## Timing
- Reset values: state IDLE, all valid bits 0, `miss_addr` 0, `hit_count` 0, `miss_count` 0, `mem_read` 0, `mem_addr` 0.
- Hit latency: 0 cycles. `proc_rdata` is valid in the same cycle as the request, with `proc_stall` low.
- Miss timeline, with cycle 0 = request cycle (IDLE, `proc_stall` 1):
  - Cycles 1..R: ALLOCATE, `mem_read` 1. Cycle R is the first cycle with `mem_ready` high.
  - Cycle R+1: IDLE. The still-present request hits.
  - Total stall: R+1 cycles.
- `mem_read` drops in the cycle after `mem_ready` is sampled. `mem_ready` seen in IDLE is ignored.
- `rst` asserted in any state, including mid-ALLOCATE, takes effect at that edge. The refill is abandoned, no array write occurs, and `mem_read` is 0 from the next cycle.

## Test plan
- Reset with `rst` = 1 for 2 cycles, then `proc_read` = 1 at address 0 → `proc_stall` = 1 in cycle 0; `mem_read` = 1 and `mem_addr` = 0 from cycle 1. Memory returns 128'h00000013_00100093_00200113_00300193 with `mem_ready` at cycle 3. Then `proc_stall` = 0 and `proc_rdata` = 32'h00300193 in cycle 4; `miss_count` = 1.
- Sequential hits: addresses 1, 2, 3 on consecutive cycles → no stall; data 32'h00200113, 32'h00100093, 32'h00000013; `hit_count` increments by 1 per cycle.
- Conflict eviction with `NUM_BLOCKS` = 8: read address 32 (same index as 0, different tag) → miss with `mem_addr` = 8. Afterwards, address 0 misses again; `miss_count` = 3.
- Write ignored: `proc_write` = 1, `proc_read` = 0, random address and data → `proc_stall` = 0, `mem_read` = 0, `mem_write` = 0, cached contents unchanged.
- Address change mid-refill: miss at address 4, then change `proc_addr` to 40 during ALLOCATE → `mem_addr` stays 1. After refill, address 40 misses with `mem_addr` = 10.
- Reset mid-refill: assert `rst` at cycle 2 of ALLOCATE → `mem_read` = 0 on the next cycle, counters = 0, and address 0 misses again.

Source files
------------

// File: rtl/icache_responder.sv
// ----------------------------------------------------------------------------
// icache_responder
//
// Read-only, direct-mapped instruction cache. It serves the fetch stage and
// refills whole 4-word blocks from a 128-bit instruction memory. Hits return
// data in the request cycle. A miss holds proc_stall high while a single
// outstanding block refill completes. Fetch-side writes are ignored.
//
// Parameters
//   NUM_BLOCKS  number of 4-word blocks (power of two, >= 2)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   proc_read   fetch read request
//   proc_write  fetch write request (ignored)
//   proc_addr   30-bit word address: [1:0] word, [IDX_W+1:2] index, rest tag
//   proc_wdata  fetch write data (ignored)
//   proc_stall  request not yet served
//   proc_rdata  instruction word for proc_addr
//   mem_read    block read request to instruction memory
//   mem_write   always 0
//   mem_addr    28-bit block address of the refill (0 when idle)
//   mem_wdata   always 0
//   mem_rdata   128-bit refill data, word k at bits [32k+31:32k]
//   mem_ready   mem_rdata valid this cycle
//   hit_count   served read cycles, wraps modulo 2^32
//   miss_count  refills started, wraps modulo 2^32
// ----------------------------------------------------------------------------
module icache_responder #(
   parameter int NUM_BLOCKS = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic         proc_stall,
   output logic [31:0]  proc_rdata,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
);

   localparam int IDX_W = $clog2(NUM_BLOCKS);
   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic {
      S_IDLE,
      S_ALLOCATE
   } state_t;

   state_t               state;
   state_t               state_next;

   logic [NUM_BLOCKS-1:0] valid;
   logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
   logic [127:0]          data_mem [NUM_BLOCKS];
   logic [27:0]           miss_addr;

   logic [IDX_W-1:0]      idx;
   logic [TAG_W-1:0]      tag;
   logic [1:0]            word;
   logic [127:0]          line;
   logic                  hit;
   logic                  refill;
   logic [IDX_W-1:0]      fill_idx;
   logic [TAG_W-1:0]      fill_tag;

   // Fetch writes have no effect on this read-only cache.
   logic                  unused_inputs;
   assign unused_inputs = ^{proc_write, proc_wdata};

   assign idx  = proc_addr[IDX_W+1:2];
   assign tag  = proc_addr[29:IDX_W+2];
   assign word = proc_addr[1:0];
   assign line = data_mem[idx];
   assign hit  = valid[idx] && (tag_mem[idx] == tag);

   // Read data is always taken from the array; it only matters when a read
   // is being served, so no extra muxing on hit is needed.
   assign proc_rdata = line[{word, 5'd0} +: 32];

   // The refill target always comes from the latched miss address, never
   // from the live fetch address.
   assign fill_idx = miss_addr[IDX_W-1:0];
   assign fill_tag = miss_addr[27:IDX_W];
   assign refill   = (state == S_ALLOCATE) && mem_ready;

   assign mem_write = 1'b0;
   assign mem_wdata = '0;

   // ---------------------------------------------------------------------
   // State register, miss address, valid bits and statistics counters
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         miss_addr  <= '0;
         valid      <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state <= state_next;
         if (state == S_IDLE && proc_read) begin
            if (hit) begin
               hit_count <= hit_count + 32'd1;
            end else begin
               miss_addr  <= proc_addr[29:2];
               miss_count <= miss_count + 32'd1;
            end
         end
         if (refill) begin
            valid[fill_idx] <= 1'b1;
         end
      end
   end

   // NOTE: tag and data arrays are deliberately not reset; the valid bits
   // alone decide whether their contents mean anything. The write is still
   // gated by rst so a refill abandoned by reset leaves the arrays untouched.
   always_ff @(posedge clk) begin
      if (!rst && refill) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mem_rdata;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:     if (proc_read && !hit) state_next = S_ALLOCATE;
         S_ALLOCATE: if (mem_ready)         state_next = S_IDLE;
         default:                           state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output logic
   // ---------------------------------------------------------------------
   always_comb begin
      proc_stall = 1'b0;
      mem_read   = 1'b0;
      mem_addr   = '0;
      unique case (state)
         S_IDLE: begin
            proc_stall = proc_read && !hit;
         end
         S_ALLOCATE: begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            mem_addr   = miss_addr;
         end
         default: begin
            proc_stall = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_icache_responder.sv
// ----------------------------------------------------------------------------
// tb_icache_responder
//
// Directed stimulus for icache_responder (NUM_BLOCKS = 8). A behavioural
// cache model, keyed by block number arithmetic, predicts every output on
// each falling edge; hand-computed literal expectations pin the model.
// ----------------------------------------------------------------------------
module tb_icache_responder;

   localparam int NB = 8;

   localparam logic [127:0] D0 = 128'h00000013_00100093_00200113_00300193;
   localparam logic [127:0] D1 = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
   localparam logic [127:0] D2 = 128'h11110003_11110002_11110001_11110000;
   localparam logic [127:0] D3 = 128'h22220003_22220002_22220001_22220000;
   localparam logic [127:0] DX = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

   logic         clk;
   logic         rst;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   icache_responder #(.NUM_BLOCKS(NB)) dut (
      .clk        (clk),
      .rst        (rst),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_stall (proc_stall),
      .proc_rdata (proc_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: a table of cached blocks indexed by block number
   // modulo NB, plus the block number of any refill still owed.
   // ---------------------------------------------------------------------
   bit           m_valid [NB];
   int unsigned  m_tag   [NB];
   logic [127:0] m_data  [NB];
   bit           m_busy;
   int unsigned  m_blk;
   int unsigned  m_hits;
   int unsigned  m_misses;

   function automatic bit model_hit(input logic [29:0] a);
      int unsigned blk;
      blk = int'(a) / 4;
      return m_valid[blk % NB] && (m_tag[blk % NB] == blk / NB);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
         m_busy   = 1'b0;
         m_blk    = 0;
         m_hits   = 0;
         m_misses = 0;
      end else if (m_busy) begin
         if (mem_ready) begin
            m_valid[m_blk % NB] = 1'b1;
            m_tag[m_blk % NB]   = m_blk / NB;
            m_data[m_blk % NB]  = mem_rdata;
            m_busy              = 1'b0;
         end
      end else if (proc_read) begin
         if (model_hit(proc_addr)) begin
            m_hits++;
         end else begin
            m_misses++;
            m_busy = 1'b1;
            m_blk  = int'(proc_addr) / 4;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit           e_stall;
         int unsigned  blk;
         logic [127:0] blkdata;
         e_stall = m_busy ? 1'b1 : (proc_read && !model_hit(proc_addr));
         check("model stall",      proc_stall, e_stall);
         check("model mem_read",   mem_read,   m_busy);
         check("model mem_addr",   mem_addr,   m_busy ? m_blk : 0);
         check("model mem_write",  mem_write,  0);
         check("model mem_wdata",  mem_wdata,  0);
         check("model hit_count",  hit_count,  m_hits);
         check("model miss_count", miss_count, m_misses);
         if (proc_read && !e_stall) begin
            blk     = int'(proc_addr) / 4;
            blkdata = m_data[blk % NB];
            check("model rdata", proc_rdata, blkdata[32*(int'(proc_addr) % 4) +: 32]);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      @(negedge clk);
   endtask

   // Called in the request cycle of a miss; returns in the first IDLE cycle
   // after the refill, with mem_ready high in ALLOCATE cycle r.
   task automatic refill(input logic [127:0] d, input int r);
      for (int i = 1; i <= r; i++) begin
         tick();
         if (i == r) begin
            mem_ready = 1'b1;
            mem_rdata = d;
         end
      end
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = '0;
      proc_wdata = '0;
      mem_rdata  = '0;
      mem_ready  = 1'b0;

      // Reset for two cycles, then miss at address 0.
      tick();
      chk_en = 1'b1;
      tick();
      rst       = 1'b0;
      proc_read = 1'b1;
      proc_addr = 30'd0;
      probe();
      check("c0 stall",      proc_stall, 1);
      check("c0 mem_read",   mem_read,   0);
      check("reset hits",    hit_count,  0);
      check("reset misses",  miss_count, 0);
      tick();
      probe();
      check("c1 mem_read",   mem_read,   1);
      check("c1 mem_addr",   mem_addr,   0);
      tick();
      tick();
      mem_ready = 1'b1;
      mem_rdata = D0;
      probe();
      check("c3 stall",      proc_stall, 1);
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      probe();
      check("c4 stall",      proc_stall, 0);
      check("c4 mem_read",   mem_read,   0);
      check("c4 rdata",      proc_rdata, 32'h00300193);
      check("c4 misses",     miss_count, 1);

      // Sequential hits at addresses 1, 2, 3.
      tick(); proc_addr = 30'd1; probe();
      check("hit1 stall", proc_stall, 0);
      check("hit1 rdata", proc_rdata, 32'h00200113);
      check("hit1 count", hit_count,  1);
      tick(); proc_addr = 30'd2; probe();
      check("hit2 rdata", proc_rdata, 32'h00100093);
      check("hit2 count", hit_count,  2);
      tick(); proc_addr = 30'd3; probe();
      check("hit3 rdata", proc_rdata, 32'h00000013);
      check("hit3 count", hit_count,  3);

      // Conflict eviction: address 32 shares index 0 with address 0.
      tick(); proc_addr = 30'd32; probe();
      check("evict stall", proc_stall, 1);
      tick(); probe();
      check("evict mem_addr", mem_addr, 8);
      mem_ready = 1'b1;
      mem_rdata = D1;
      tick();
      mem_ready = 1'b0;
      probe();
      check("evict rdata", proc_rdata, 32'hAAAA0000);
      tick(); proc_addr = 30'd0; probe();
      check("reload stall", proc_stall, 1);
      refill(D0, 2);
      probe();
      check("reload rdata",  proc_rdata, 32'h00300193);
      check("reload misses", miss_count, 3);

      // Writes are ignored, with or without a read; mem_ready in IDLE too.
      tick();
      proc_read  = 1'b0;
      proc_write = 1'b1;
      proc_addr  = 30'h2ABC_DEF0;
      proc_wdata = 32'hCAFE_F00D;
      mem_ready  = 1'b1;
      mem_rdata  = DX;
      probe();
      check("wr stall",     proc_stall, 0);
      check("wr mem_read",  mem_read,   0);
      check("wr mem_write", mem_write,  0);
      tick();
      mem_ready = 1'b0;
      proc_read = 1'b1;
      proc_addr = 30'd1;
      probe();
      check("wr+rd stall", proc_stall, 0);
      check("wr+rd rdata", proc_rdata, 32'h00200113);
      tick();
      proc_write = 1'b0;
      proc_addr  = 30'd0;
      probe();
      check("after wr rdata", proc_rdata, 32'h00300193);

      // Address change during refill: miss at 4, switch to 40.
      tick(); proc_addr = 30'd4; probe();
      check("chg stall", proc_stall, 1);
      tick(); proc_addr = 30'd40; probe();
      check("chg mem_addr", mem_addr, 1);
      mem_ready = 1'b1;
      mem_rdata = D2;
      tick();
      mem_ready = 1'b0;
      probe();
      check("chg new miss", proc_stall, 1);
      tick(); probe();
      check("chg mem_addr2", mem_addr, 10);
      tick();
      tick();
      mem_ready = 1'b1;
      mem_rdata = D3;
      tick();
      mem_ready = 1'b0;
      probe();
      check("chg rdata", proc_rdata, 32'h22220000);
      tick(); proc_addr = 30'd5; probe();
      check("blk1 rdata", proc_rdata, 32'h11110001);

      // Reset in the second ALLOCATE cycle, with mem_ready offered.
      tick(); proc_addr = 30'd8; probe();
      check("rst stall", proc_stall, 1);
      tick();
      tick();
      rst       = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = DX;
      probe();
      check("rst pre mem_read", mem_read, 1);
      tick();
      rst       = 1'b0;
      mem_ready = 1'b0;
      proc_read = 1'b0;
      probe();
      check("rst mem_read", mem_read,   0);
      check("rst hits",     hit_count,  0);
      check("rst misses",   miss_count, 0);
      tick();
      proc_read = 1'b1;
      proc_addr = 30'd8;
      probe();
      check("rst no fill", proc_stall, 1);
      refill(D2, 1);
      tick(); proc_addr = 30'd0; probe();
      check("rst miss0", proc_stall, 1);
      refill(D0, 3);
      probe();
      check("final rdata",  proc_rdata, 32'h00300193);
      check("final misses", miss_count, 2);

      tick();
      proc_read = 1'b0;
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
